// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch address generation, a single
// outstanding instruction-memory request, and a small FIFO of {instr, pc+4}
// entries presented to the decode register.
//
// Handshakes:
//   memory side: mem_req_o rises with mem_addr_o, and both stay stable until
//   mem_ack_i. A transfer completes on the rising edge where mem_req_o and
//   mem_ack_i are both high. mem_ack_i is ignored while mem_req_o is low.
//   decode side: the head entry is consumed on the rising edge where
//   instr_valid_o is high, stall_i is low and redirect_i is low.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,            // power of two, >= 2
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // IDLE: no request outstanding. REQ: request whose data will be kept.
    // DROP: request still outstanding after a redirect; its data is discarded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       fetch_pc_d;
    logic [31:0]       addr_q;
    logic [31:0]       addr_d;
    logic [31:0]       redirect_target;

    logic [31:0]       instr_mem [DEPTH];
    logic [31:0]       pc4_mem   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_after;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;

    // Low two bits of the redirect target are forced to zero (word aligned).
    assign redirect_target = redirect_pc_i & ~32'h0000_0003;

    // A redirect suppresses both the pop and any same-edge push.
    assign fifo_nonempty = (count_q != '0);
    assign push          = (state_q == ST_REQ) & mem_ack_i & ~redirect_i;
    assign pop           = fifo_nonempty & ~stall_i & ~redirect_i;
    assign count_after   = count_q + CNT_W'(push) - CNT_W'(pop);

    // FSM state, fetch PC and the held request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state logic: issue requests while there is room, and never
    // withdraw a request before its ack (redirect mid-request goes to DROP).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_target;
                end else if (count_q < DEPTH_C) begin
                    state_d = ST_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_target;
                    state_d    = mem_ack_i ? ST_IDLE : ST_DROP;
                end else if (mem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (count_after < DEPTH_C) begin
                        // Back-to-back: the next request starts immediately.
                        addr_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_target;
                end
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk) begin
        if (rst || redirect_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_after;
        end
    end

    // FIFO storage; the entry carries the word and the PC of the next word.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= mem_rdata_i;
            pc4_mem[wr_ptr_q]   <= addr_q + 32'd4;
        end
    end

    assign mem_req_o     = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign mem_addr_o    = addr_q;
    assign instr_valid_o = fifo_nonempty;
    assign instr_o       = fifo_nonempty ? instr_mem[rd_ptr_q] : 32'd0;
    assign pc_plus4_o    = fifo_nonempty ? pc4_mem[rd_ptr_q]   : 32'd0;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: a latency-configurable memory responder,
// a transaction-level reference model of the fetch stream and buffer, and
// directed plus random stimulus.
module tb_instr_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;

    // Responder knobs, written by the stimulus process only.
    int   lat       = 1;
    logic rand_data = 1'b0;
    logic stray_ack = 1'b0;

    // Reference model, written by the monitor process only.
    logic [63:0] exp_q[$];
    logic [31:0] model_pc  = RESET_PC;
    logic [31:0] pend_addr = RESET_PC;
    logic        pending   = 1'b0;
    logic        dropping  = 1'b0;
    logic        prev_rst  = 1'b0;
    int          idle_cnt  = 0;

    instr_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .pc_plus4_o    (pc_plus4)
    );

    // Clock and reset-free clock generation
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_req(input logic [31:0] addr, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (mem_req && mem_addr == addr) found = 1'b1;
            else tick();
        end
        chk("wait_req", {31'd0, found}, 32'd1);
    endtask

    // Memory responder: acks the lat-th cycle of each request; when no
    // request is up, it may present a stray ack that must be ignored.
    initial begin : responder
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (wait_cnt + 1 >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rand_data ? $urandom : mem_addr;
                    wait_cnt  = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                wait_cnt  = 0;
                mem_ack   = stray_ack;
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor/scoreboard: compares the presented head against the expected
    // queue every cycle, checks request addresses against the model's fetch
    // PC, then applies the upcoming edge to the model.
    initial begin : monitor
        logic take;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("rst_req", {31'd0, mem_req}, 32'd0);
                chk("rst_addr", mem_addr, RESET_PC);
                chk("rst_valid", {31'd0, instr_valid}, 32'd0);
                chk("rst_instr", instr, 32'd0);
                chk("rst_pc4", pc_plus4, 32'd0);
            end
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("instr", instr, exp_q[0][63:32]);
                chk("pc_plus4", pc_plus4, exp_q[0][31:0]);
            end else begin
                chk("instr_empty", instr, 32'd0);
                chk("pc_plus4_empty", pc_plus4, 32'd0);
            end
            if (pending) begin
                chk("req_held", {31'd0, mem_req}, 32'd1);
                chk("addr_hold", mem_addr, pend_addr);
            end else if (mem_req) begin
                chk("req_addr", mem_addr, model_pc);
                chk("req_room", {31'd0, exp_q.size() < DEPTH}, 32'd1);
                pending   = 1'b1;
                pend_addr = model_pc;
            end
            if (rst || redirect || mem_req || exp_q.size() == DEPTH) idle_cnt = 0;
            else idle_cnt++;
            chk("req_idle", {31'd0, idle_cnt > 2}, 32'd0);

            take = mem_req && mem_ack;
            if (rst) begin
                exp_q.delete();
                model_pc = RESET_PC;
                pending  = 1'b0;
                dropping = 1'b0;
            end else if (redirect) begin
                exp_q.delete();
                model_pc = redirect_pc & ~32'h3;
                if (take) begin
                    pending  = 1'b0;
                    dropping = 1'b0;
                end else if (mem_req) begin
                    dropping = 1'b1;
                end
            end else begin
                if (exp_q.size() != 0 && !stall) void'(exp_q.pop_front());
                if (take) begin
                    pending = 1'b0;
                    if (dropping) begin
                        dropping = 1'b0;
                    end else begin
                        exp_q.push_back({mem_rdata, pend_addr + 32'd4});
                        model_pc = pend_addr + 32'd4;
                    end
                end
            end
            prev_rst = rst;
        end
    end

    // Stimulus
    initial begin : stimulus
        logic [31:0] target;
        int          guard;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        stall       = 1'b0;

        // Reset release and first-fetch latency with a 1-cycle memory.
        tick(2);
        rst = 1'b0;
        tick();
        chk("lat_req", {31'd0, mem_req}, 32'd1);
        chk("lat_valid0", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_instr", instr, RESET_PC);
        chk("first_pc4", pc_plus4, RESET_PC + 32'd4);
        tick(12);

        // Stall fills the buffer; requests stop, then resume on drain.
        stall = 1'b1;
        tick(10);
        chk("stall_req_off", {31'd0, mem_req}, 32'd0);
        chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b0;
        tick(12);

        // Redirect during a slow request: DROP holds the old address.
        lat = 3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_req(32'h8, 40);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        chk("drop_req", {31'd0, mem_req}, 32'd1);
        chk("drop_addr", mem_addr, 32'h8);
        chk("drop_valid", {31'd0, instr_valid}, 32'd0);
        wait_req(32'h100, 20);
        chk("redir_empty", {31'd0, instr_valid}, 32'd0);
        tick(10);

        // Redirect coincident with an ack while two entries are queued.
        lat   = 1;
        stall = 1'b1;
        guard = 0;
        while (exp_q.size() != 2 && guard < 30) begin
            tick();
            guard++;
        end
        chk("rc_setup", {31'd0, exp_q.size() == 2 && mem_ack}, 32'd1);
        target      = $urandom;
        redirect    = 1'b1;
        redirect_pc = target;
        stall       = 1'b0;
        tick();
        redirect = 1'b0;
        chk("rc_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("rc_req", {31'd0, mem_req}, 32'd1);
        chk("rc_addr", mem_addr, target & ~32'h3);
        tick(6);

        // Reset while in DROP with the ack still pending; stray ack after.
        lat   = 4;
        guard = 0;
        while (!(mem_req && !mem_ack) && guard < 20) begin
            tick();
            guard++;
        end
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("drop2_req", {31'd0, mem_req}, 32'd1);
        rst       = 1'b1;
        stray_ack = 1'b1;
        tick();
        rst       = 1'b0;
        stray_ack = 1'b0;
        chk("rst_drop_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("rst_refetch_req", {31'd0, mem_req}, 32'd1);
        chk("rst_refetch_addr", mem_addr, RESET_PC);
        chk("stray_ignored", {31'd0, instr_valid}, 32'd0);
        tick(8);

        // Address wrap at 2^32.
        lat         = 1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        wait_req(32'hFFFF_FFFC, 10);
        tick();
        chk("wrap_pc4", pc_plus4, 32'h0);
        chk("wrap_next_addr", mem_addr, 32'h0);
        tick(6);

        // Random traffic.
        rand_data = 1'b1;
        for (int i = 0; i < 800; i++) begin
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 4);
            redirect_pc = $urandom;
            rst         = ($urandom_range(0, 199) == 0);
            stray_ack   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
            tick();
        end
        stall     = 1'b0;
        redirect  = 1'b0;
        rst       = 1'b0;
        stray_ack = 1'b0;
        tick(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
